rdl_apb_bridge: RTL and testbench
=================================

RDL_APB_BRIDGE -- requirements
Module: rdl_apb_bridge

Interface
REQ-001 SHALL have parameter AW, default 12: address width in bits.
REQ-002 SHALL have parameter DW, default 32: data width in bits, legal values 32 only.
REQ-003 SHALL have parameter RdLatency, default 1: cycles from the reg_re pulse to valid reg_rd, legal range 0..3.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port psel, input, 1: APB select.
REQ-007 SHALL have port penable, input, 1: APB enable (access phase).
REQ-008 SHALL have port pwrite, input, 1: APB direction, 1 = write.
REQ-009 SHALL have port paddr, input, AW: APB byte address.
REQ-010 SHALL have port pwdata, input, DW: APB write data.
REQ-011 SHALL have port pstrb, input, DW/8: APB byte strobes.
REQ-012 SHALL have port pready, output, 1: APB transfer complete.
REQ-013 SHALL have port prdata, output, DW: APB read data.
REQ-014 SHALL have port pslverr, output, 1: APB error response.
REQ-015 SHALL have port reg_addr, output, AW: latched register address.
REQ-016 SHALL have port reg_wd, output, DW: latched write data.
REQ-017 SHALL have port reg_be, output, DW/8: latched byte enables.
REQ-018 SHALL have port reg_we, output, 1: single-cycle write strobe to the register bank.
REQ-019 SHALL have port reg_re, output, 1: single-cycle read strobe to the register bank.
REQ-020 SHALL have port reg_rd, input, DW: register bank read data.
REQ-021 SHALL have port reg_err, input, 1: register bank error (address decode miss).

Function
REQ-022 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP, with all outputs driven from flops.
REQ-023 In IDLE, a setup phase (psel=1, penable=0) SHALL capture paddr, pwdata, pstrb and pwrite into reg_addr, reg_wd, reg_be and an internal direction flop, and then move to ISSUE.
REQ-024 ISSUE SHALL last exactly one cycle and assert reg_we (write) or reg_re (read) for that cycle only.
REQ-025 A write SHALL go ISSUE->RESP, so pready is high in the cycle after reg_we (two cycles after setup).
REQ-026 A read SHALL go ISSUE->WAIT, and WAIT SHALL hold for RdLatency cycles; RdLatency=0 skips WAIT and samples reg_rd in the ISSUE cycle.
REQ-027 A read SHALL sample reg_rd and reg_err exactly RdLatency cycles after the reg_re cycle.
REQ-028 A read SHALL assert pready in the cycle after reg_rd is sampled, so pready occurs RdLatency+2 cycles after setup.
REQ-029 RESP SHALL assert pready for exactly one cycle and then return to IDLE.
REQ-030 A setup phase arriving in that same RESP cycle SHALL be ignored.
REQ-031 prdata SHALL equal the sampled reg_rd only while pready=1 on a read, and SHALL be 0 otherwise.
REQ-032 pslverr SHALL be valid only with pready, and SHALL be the OR of reg_err (sampled in the reg_we cycle for writes, per REQ-027 for reads) and misalignment.
REQ-033 A misaligned access (paddr[1:0] != 0) SHALL issue no reg_we/reg_re, SHALL go directly ISSUE->RESP, and SHALL respond pslverr=1, prdata=0.
REQ-034 A write with pstrb=0 SHALL suppress reg_we and complete with pready and pslverr=0.
REQ-035 If psel drops in WAIT or RESP, the FSM SHALL return to IDLE without pready; a strobe already issued SHALL NOT be retracted.
REQ-036 The WAIT counter SHALL be clog2(4) bits wide, SHALL load RdLatency-1 on entry, SHALL count down, and SHALL NOT wrap.
REQ-037 reg_addr, reg_wd and reg_be SHALL hold stable from capture until the next setup phase.
REQ-038 reg_we and reg_re SHALL never both be 1.

Reset
REQ-039 While rst_n=0, the FSM SHALL be IDLE and pready, pslverr, reg_we and reg_re SHALL be 0.
REQ-040 While rst_n=0, prdata, reg_addr, reg_wd and reg_be SHALL be 0, and the counter SHALL be 0.
REQ-041 Reset asserted mid-transfer SHALL abort the transfer immediately with no pready.
REQ-042 After rst_n deasserts, the first setup phase SHALL be accepted no earlier than the first rising edge with rst_n=1.

Verification
REQ-043 Write with paddr=0x010, pwdata=0xDEADBEEF, pstrb=0xF -> reg_we pulses one cycle with reg_addr=0x010, reg_wd=0xDEADBEEF, reg_be=0xF; pready=1 two cycles after setup; pslverr=0.
REQ-044 Read with RdLatency=2, paddr=0x020, reg_rd=0x12345678 -> reg_re pulses once; pready=1 four cycles after setup; prdata=0x12345678.
REQ-045 Read with paddr=0x023 -> no reg_re; pready=1 with pslverr=1 and prdata=0.
REQ-046 Read with reg_err=1 in the sample cycle -> pslverr=1; write with pstrb=0 -> no reg_we, pslverr=0.
REQ-047 Back-to-back writes with RdLatency=0 reads interleaved -> each transfer gets exactly one strobe and one pready, and reg_we/reg_re are never both high.
REQ-048 rst_n pulled low in WAIT -> all outputs 0 asynchronously; the next transfer completes normally.

Source files
------------

// File: rtl/rdl_apb_bridge_if.sv
// rtl/rdl_apb_bridge_if.sv - APB slave port plus register-bank strobe bus
interface rdl_apb_bridge_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    // APB side
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [DW/8-1:0]   pstrb;
    logic              pready;
    logic [DW-1:0]     prdata;
    logic              pslverr;
    // register-bank side
    logic [AW-1:0]     reg_addr;
    logic [DW-1:0]     reg_wd;
    logic [DW/8-1:0]   reg_be;
    logic              reg_we;
    logic              reg_re;
    logic [DW-1:0]     reg_rd;
    logic              reg_err;

    // The bridge: APB slave, register-bank master
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, reg_rd, reg_err,
        output pready, prdata, pslverr, reg_addr, reg_wd, reg_be, reg_we, reg_re
    );

    // The surroundings: APB master plus register bank
    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, reg_rd, reg_err,
        input  pready, prdata, pslverr, reg_addr, reg_wd, reg_be, reg_we, reg_re
    );
endinterface

// File: rtl/rdl_apb_bridge.sv
// rtl/rdl_apb_bridge.sv - APB slave to single-strobe register-bank bridge
module rdl_apb_bridge #(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int RdLatency = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    rdl_apb_bridge_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CntW = $clog2(4);
    // WAIT is entered only when RdLatency >= 1, so the load value never underflows
    localparam logic [CntW-1:0] WaitLoad = CntW'(RdLatency > 0 ? RdLatency - 1 : 0);

    state_t             state_q;
    logic [CntW-1:0]    cnt_q;
    logic               dir_q;      // 1 = write
    logic               mis_q;      // captured address was not word aligned
    logic               pready_q;
    logic               pslverr_q;
    logic [DW-1:0]      prdata_q;
    logic [AW-1:0]      reg_addr_q;
    logic [DW-1:0]      reg_wd_q;
    logic [DW/8-1:0]    reg_be_q;
    logic               reg_we_q;
    logic               reg_re_q;

    logic               setup_d;
    logic               mis_d;

    assign setup_d = bus.psel & ~bus.penable;
    assign mis_d   = |bus.paddr[1:0];

    // Transfer sequencer: every output below is a flop set one state ahead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            mis_q      <= 1'b0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            reg_addr_q <= '0;
            reg_wd_q   <= '0;
            reg_be_q   <= '0;
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
        end else begin
            // strobes are single-cycle: they are only ever raised on the IDLE->ISSUE step
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (setup_d) begin
                        reg_addr_q <= bus.paddr;
                        reg_wd_q   <= bus.pwdata;
                        reg_be_q   <= bus.pstrb;
                        dir_q      <= bus.pwrite;
                        mis_q      <= mis_d;
                        // misaligned accesses and empty-strobe writes never reach the bank
                        reg_we_q   <= bus.pwrite & ~mis_d & (|bus.pstrb);
                        reg_re_q   <= ~bus.pwrite & ~mis_d;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mis_q || dir_q || (RdLatency == 0)) begin
                        // reg_err only counts when a strobe actually went out this cycle
                        state_q   <= RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= mis_q | ((reg_we_q | reg_re_q) & bus.reg_err);
                        prdata_q  <= reg_re_q ? bus.reg_rd : '0;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= WaitLoad;
                    end
                end
                WAIT: begin
                    if (!bus.psel) begin
                        // master gave up: drop the transfer, the issued read stays issued
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q   <= RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= bus.reg_err;
                        prdata_q  <= bus.reg_rd;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    // any setup seen here is ignored; the master re-presents it next cycle
                    state_q   <= IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pready   = pready_q;
    assign bus.pslverr  = pslverr_q;
    assign bus.prdata   = prdata_q;
    assign bus.reg_addr = reg_addr_q;
    assign bus.reg_wd   = reg_wd_q;
    assign bus.reg_be   = reg_be_q;
    assign bus.reg_we   = reg_we_q;
    assign bus.reg_re   = reg_re_q;
endmodule

// File: tb/tb_rdl_apb_bridge.sv
// tb/tb_rdl_apb_bridge.sv - randomized APB transfers against a transfer-level model
module tb_rdl_apb_bridge;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam logic [31:0] MissData = 32'hBADC0DE0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // sel=1 routes the APB master to the RdLatency=2 bridge, sel=0 to the RdLatency=0 one
    logic        sel = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] reg_rd;
    logic        reg_err;

    rdl_apb_bridge_if #(.AW(AW), .DW(DW)) bus2 ();
    rdl_apb_bridge_if #(.AW(AW), .DW(DW)) bus0 ();

    assign bus2.psel = psel & sel;
    assign bus0.psel = psel & ~sel;
    assign bus2.penable = penable;  assign bus0.penable = penable;
    assign bus2.pwrite  = pwrite;   assign bus0.pwrite  = pwrite;
    assign bus2.paddr   = paddr;    assign bus0.paddr   = paddr;
    assign bus2.pwdata  = pwdata;   assign bus0.pwdata  = pwdata;
    assign bus2.pstrb   = pstrb;    assign bus0.pstrb   = pstrb;
    assign bus2.reg_rd  = reg_rd;   assign bus0.reg_rd  = reg_rd;
    assign bus2.reg_err = reg_err;  assign bus0.reg_err = reg_err;

    rdl_apb_bridge #(.AW(AW), .DW(DW), .RdLatency(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    rdl_apb_bridge #(.AW(AW), .DW(DW), .RdLatency(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    logic        pready_m, pslverr_m, we_m, re_m;
    logic [31:0] prdata_m, wd_m;
    logic [11:0] addr_m;
    logic [3:0]  be_m;
    assign pready_m  = sel ? bus2.pready   : bus0.pready;
    assign pslverr_m = sel ? bus2.pslverr  : bus0.pslverr;
    assign prdata_m  = sel ? bus2.prdata   : bus0.prdata;
    assign we_m      = sel ? bus2.reg_we   : bus0.reg_we;
    assign re_m      = sel ? bus2.reg_re   : bus0.reg_re;
    assign wd_m      = sel ? bus2.reg_wd   : bus0.reg_wd;
    assign addr_m    = sel ? bus2.reg_addr : bus0.reg_addr;
    assign be_m      = sel ? bus2.reg_be   : bus0.reg_be;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A50000 ^ (i * 32'h00010203);
    endfunction

    // Register bank: 64 words below 0x100, decode miss above. Read data and error are only
    // truthful in the exact cycle the bridge is supposed to sample them; otherwise inverted.
    logic [31:0] bank_mem [64];
    logic [3:0]  age_q;
    logic [3:0]  age_now;
    logic [3:0]  lat_cur;
    logic        miss_m;
    logic [31:0] bank_val;
    assign miss_m   = addr_m >= 12'h100;
    assign age_now  = re_m ? 4'd0 : age_q;
    assign lat_cur  = sel ? 4'd2 : 4'd0;
    assign bank_val = miss_m ? MissData : bank_mem[addr_m[7:2]];
    assign reg_rd   = (age_now == lat_cur) ? bank_val : ~bank_val;
    assign reg_err  = (we_m || age_now == lat_cur) ? miss_m : ~miss_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= 4'd15;
            for (int i = 0; i < 64; i++) bank_mem[i] <= init_word(i);
        end else begin
            age_q <= re_m ? 4'd1 : ((age_q == 4'd15) ? 4'd15 : age_q + 4'd1);
            if (we_m && !miss_m)
                for (int b = 0; b < 4; b++)
                    if (be_m[b]) bank_mem[addr_m[7:2]][8*b +: 8] <= wd_m[8*b +: 8];
        end
    end

    // Transfer-level reference model
    logic [31:0] model_mem [64];
    int checks = 0;
    int failures = 0;
    logic pending = 1'b0;

    task automatic init_model();
        for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_done();
        if (pending) chk("pready_single_cycle", {31'b0, pready_m}, 32'h0);
        pending = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        check_done();
        psel = 1'b0;
        penable = 1'b0;
    endtask

    task automatic xfer(input logic s, input logic wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        logic mis, miss, exp_we, exp_re, exp_err, got_err;
        logic [31:0] exp_rd, got_rd;
        int exp_lat, lat, nwe, nre, both;
        mis     = a[1:0] != 2'b00;
        miss    = a >= 12'h100;
        exp_we  = wr && !mis && be != 4'h0;
        exp_re  = !wr && !mis;
        exp_lat = exp_re ? (s ? 4 : 2) : 2;
        exp_err = mis || (miss && (exp_we || exp_re));
        exp_rd  = exp_re ? (miss ? MissData : model_mem[a[7:2]]) : 32'h0;
        if (exp_we && !miss)
            for (int b = 0; b < 4; b++)
                if (be[b]) model_mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
        @(negedge clk);
        check_done();
        sel = s; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = be;
        lat = 0; nwe = 0; nre = 0; both = 0; got_rd = 'x; got_err = 1'bx;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk);
            penable = 1'b1;
            if (we_m) begin
                nwe++;
                chk("reg_addr_wr", {20'b0, addr_m}, {20'b0, a});
                chk("reg_wd", wd_m, wd);
                chk("reg_be", {28'b0, be_m}, {28'b0, be});
            end
            if (re_m) begin
                nre++;
                chk("reg_addr_rd", {20'b0, addr_m}, {20'b0, a});
            end
            if (we_m && re_m) both++;
            if (pready_m) begin
                lat = k;
                got_rd = prdata_m;
                got_err = pslverr_m;
            end
        end
        chk("latency", lat, exp_lat);
        chk("prdata", got_rd, exp_rd);
        chk("pslverr", {31'b0, got_err}, {31'b0, exp_err});
        chk("we_count", nwe, {31'b0, exp_we});
        chk("re_count", nre, {31'b0, exp_re});
        chk("we_re_overlap", both, 0);
        pending = 1'b1;
    endtask

    int seen_ready, nre_abort;
    logic        r_wr;
    logic [11:0] r_addr;
    int          r_kind;

    initial begin
        init_model();
        // setup phase held during reset must be ignored
        sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pstrb = 4'hF;
        pwdata = 32'h11111111;
        repeat (3) @(negedge clk);
        chk("rst_pready2",  {31'b0, bus2.pready},  0);
        chk("rst_pslverr2", {31'b0, bus2.pslverr}, 0);
        chk("rst_prdata2",  bus2.prdata, 0);
        chk("rst_we2",      {31'b0, bus2.reg_we},  0);
        chk("rst_re2",      {31'b0, bus2.reg_re},  0);
        chk("rst_addr2",    {20'b0, bus2.reg_addr}, 0);
        chk("rst_wd2",      bus2.reg_wd, 0);
        chk("rst_be2",      {28'b0, bus2.reg_be}, 0);
        chk("rst_pready0",  {31'b0, bus0.pready},  0);
        chk("rst_we0",      {31'b0, bus0.reg_we},  0);
        psel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // directed transfers
        xfer(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
        xfer(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        xfer(1'b1, 1'b1, 12'h020, 32'h12345678, 4'hF);
        xfer(1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
        xfer(1'b1, 1'b0, 12'h023, 32'h0, 4'h0);
        xfer(1'b1, 1'b0, 12'h104, 32'h0, 4'h0);
        xfer(1'b0, 1'b1, 12'h030, 32'hCAFEF00D, 4'h0);
        xfer(1'b0, 1'b0, 12'h030, 32'h0, 4'h0);
        xfer(1'b0, 1'b1, 12'h034, 32'hA1B2C3D4, 4'b0101);
        xfer(1'b0, 1'b0, 12'h034, 32'h0, 4'h0);
        xfer(1'b0, 1'b1, 12'h108, 32'h55AA55AA, 4'hF);
        xfer(1'b1, 1'b1, 12'h041, 32'h77777777, 4'hF);

        // back-to-back writes with RdLatency=0 reads interleaved
        for (int i = 0; i < 8; i++)
            xfer(1'b0, (i % 2) == 0, {4'h0, 2'(i % 4), 4'($urandom_range(0, 15)), 2'b00},
                 $urandom, 4'($urandom_range(1, 15)));

        // read abandoned in WAIT: one reg_re, no pready
        idle();
        sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h020;
        nre_abort = 0; seen_ready = 0;
        @(negedge clk); penable = 1'b1;
        if (re_m) nre_abort++;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pready_m) seen_ready++;
            if (re_m) nre_abort++;
        end
        chk("abort_no_pready", seen_ready, 0);
        chk("abort_one_re", nre_abort, 1);
        xfer(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);

        // reset pulled in WAIT clears outputs without waiting for a clock
        idle();
        sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h024;
        @(negedge clk); penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_pready",  {31'b0, bus2.pready},  0);
        chk("arst_pslverr", {31'b0, bus2.pslverr}, 0);
        chk("arst_prdata",  bus2.prdata, 0);
        chk("arst_re",      {31'b0, bus2.reg_re},  0);
        chk("arst_we",      {31'b0, bus2.reg_we},  0);
        chk("arst_addr",    {20'b0, bus2.reg_addr}, 0);
        chk("arst_be",      {28'b0, bus2.reg_be}, 0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        init_model();
        xfer(1'b1, 1'b1, 12'h024, 32'h0BADF00D, 4'hF);
        xfer(1'b1, 1'b0, 12'h024, 32'h0, 4'h0);

        // randomized mix across both bridges
        for (int i = 0; i < 40; i++) begin
            r_kind = $urandom_range(0, 9);
            r_wr = 1'($urandom_range(0, 1));
            if (r_kind < 7)       r_addr = {4'h0, 6'($urandom_range(0, 63)), 2'b00};
            else if (r_kind == 7) r_addr = {4'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            else                  r_addr = {4'($urandom_range(1, 15)), 6'($urandom_range(0, 63)), 2'b00};
            xfer(1'($urandom_range(0, 1)), r_wr, r_addr, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
